// File: rtl/mtype_pkg.sv
// Shared encodings for the matrix-extension scheduler: engine opcodes, FSM states, instruction match keys.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// The match keys are {funct3, opcode}. They come from the MtypePA/MtypeM2/MtypeS
// defines when the including build already provides them. Otherwise the
// custom-0 defaults below are used.
`ifndef MtypePA
`define MtypePA 10'b000_0001011
`endif
`ifndef MtypeM2
`define MtypeM2 10'b001_0001011
`endif
`ifndef MtypeS
`define MtypeS  10'b010_0001011
`endif

package mtype_pkg;

    // Engine opcodes; 2'd3 is reserved and never issued.
    localparam logic [1:0] OP_PA = 2'd0;
    localparam logic [1:0] OP_M2 = 2'd1;
    localparam logic [1:0] OP_S  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_MUL   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [9:0] MATCH_PA = `MtypePA;
    localparam logic [9:0] MATCH_M2 = `MtypeM2;
    localparam logic [9:0] MATCH_S  = `MtypeS;

endpackage

// File: rtl/mtype_decode.sv
// Classifies a 32-bit instruction as one of the matrix-extension ops.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_inst   - instruction word
//        o_is_custom - instruction is PA, M2 or S
//        o_op     - engine opcode (OP_PA when not custom)
module mtype_decode
    import mtype_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic        o_is_custom,
    output logic [1:0]  o_op
);

    logic [9:0] w_key;
    assign w_key = {i_inst[14:12], i_inst[6:0]};

    always_comb begin
        o_is_custom = 1'b0;
        o_op        = OP_PA;
        if (w_key == MATCH_PA) begin
            o_is_custom = 1'b1;
            o_op        = OP_PA;
        end else if (w_key == MATCH_M2) begin
            o_is_custom = 1'b1;
            o_op        = OP_M2;
        end else if (w_key == MATCH_S) begin
            o_is_custom = 1'b1;
            o_op        = OP_S;
        end
    end

    // Operand and destination fields play no part in classification.
    logic w_unused;
    assign w_unused = ^{i_inst[31:15], i_inst[11:7]};

endmodule

// File: rtl/mtype_scheduler.sv
// Sequences one matrix-extension op at a time onto the shared engine and interlocks ID behind it.
// Latency: eng_req rises one cycle after EX acceptance; busy covers ISSUE through completion.
// Backpressure: stall holds IF/ID while an op is in flight or being accepted; eng_req holds until eng_ack.
//
// Ports: clk, rst (sync, active-high)
//        id_valid/id_inst  - ID stage instruction (only used for the stall interlock)
//        ex_valid/ex_inst  - EX stage instruction (source of accepted ops)
//        eng_req/eng_op    - registered request + opcode to the engine, stable until eng_ack
//        eng_ack/eng_done  - engine accept / store-complete
//        busy              - op in flight (registered)
//        stall             - combinational ID hold
// Optional: define MTYPE_PERF_EN to add perf_busy_cycles[31:0] and perf_ops[15:0].
module mtype_scheduler
    import mtype_pkg::*;
#(
    parameter int MUL_LAT = 4,   // M2 cycles after ack, 1..15
    parameter int CNT_W   = 4    // 2**CNT_W must exceed MUL_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_valid,
    input  logic [31:0] ex_inst,
    output logic        eng_req,
    output logic [1:0]  eng_op,
    input  logic        eng_ack,
    input  logic        eng_done,
    output logic        busy,
    output logic        stall
`ifdef MTYPE_PERF_EN
    ,
    output logic [31:0] perf_busy_cycles,
    output logic [15:0] perf_ops
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    logic             w_id_custom;
    logic [1:0]       w_id_op_unused;
    logic             w_ex_custom;
    logic [1:0]       w_ex_op;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic             r_eng_req;
    logic             r_busy;
    logic             w_ex_accept;

    mtype_decode u_dec_id (
        .i_inst      (id_inst),
        .o_is_custom (w_id_custom),
        .o_op        (w_id_op_unused)
    );

    mtype_decode u_dec_ex (
        .i_inst      (ex_inst),
        .o_is_custom (w_ex_custom),
        .o_op        (w_ex_op)
    );

    assign w_ex_accept = (r_state == ST_IDLE) && ex_valid && w_ex_custom;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (w_ex_accept) begin
                    w_state_nxt = ST_ISSUE;
                    w_op_nxt    = w_ex_op;
                end
            end
            ST_ISSUE: begin
                if (eng_ack) begin
                    case (r_op)
                        OP_M2: begin
                            w_state_nxt = ST_MUL;
                            w_cnt_nxt   = CNT_INIT;
                        end
                        // A store may complete in the same cycle it is accepted.
                        OP_S:    w_state_nxt = eng_done ? ST_IDLE : ST_WAIT;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // eng_req and busy are registered from the next state so they change
    // exactly at the state edge and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= OP_PA;
            r_eng_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_eng_req <= (w_state_nxt == ST_ISSUE);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign eng_req = r_eng_req;
    assign eng_op  = r_op;
    assign busy    = r_busy;

    // The accepting cycle stalls too, so a second custom op cannot slip into
    // EX behind the one just taken.
    assign stall = id_valid && w_id_custom && (r_busy || w_ex_accept);

`ifdef MTYPE_PERF_EN
    logic [31:0] r_perf_busy;
    logic [15:0] r_perf_ops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy <= '0;
            r_perf_ops  <= '0;
        end else begin
            if (r_busy) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) begin
                r_perf_ops <= r_perf_ops + 16'd1;
            end
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_ops         = r_perf_ops;
`endif

endmodule

// File: tb/tb_mtype_scheduler.sv
module tb_mtype_scheduler;

    localparam int MUL_LAT = 4;
    localparam logic [6:0] OPC_CUST = 7'b0001011;
    localparam logic [6:0] OPC_ALU  = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic        eng_req;
    logic [1:0]  eng_op;
    logic        eng_ack;
    logic        eng_done;
    logic        busy;
    logic        stall;
`ifdef MTYPE_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_ops;
`endif

    mtype_scheduler #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .ex_valid (ex_valid),
        .ex_inst  (ex_inst),
        .eng_req  (eng_req),
        .eng_op   (eng_op),
        .eng_ack  (eng_ack),
        .eng_done (eng_done),
        .busy     (busy),
        .stall    (stall)
`ifdef MTYPE_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_ops         (perf_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Instruction classification from the ISA table: -1 = not a matrix op.
    function automatic int classify(input logic [31:0] inst);
        if (inst[6:0] != OPC_CUST) return -1;
        case (inst[14:12])
            3'd0:    return 0;
            3'd1:    return 1;
            3'd2:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
        logic [31:0] r;
        r        = $urandom;
        r[14:12] = f3;
        r[6:0]   = opc;
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        case ($urandom_range(0, 5))
            0:       return mk(3'd0, OPC_CUST);
            1:       return mk(3'd1, OPC_CUST);
            2:       return mk(3'd2, OPC_CUST);
            3:       return mk(3'd3, OPC_CUST);
            4:       return mk(3'd0, OPC_ALU);
            default: return $urandom;
        endcase
    endfunction

    // Reference model: one op "in flight" record. An M2 finishes a fixed
    // MUL_LAT cycles after the cycle its ack arrives; PA at ack; S at done.
    int          cyc = 0;
    bit          m_inflight = 0;
    bit          m_acked = 0;
    int          m_op = 0;
    int          m_idle_at = 0;
    logic [31:0] m_perf_busy = 0;
    logic [15:0] m_perf_ops = 0;

    always @(posedge clk) begin
        int eop;
        if (rst) begin
            m_inflight  = 0;
            m_acked     = 0;
            m_op        = 0;
            m_perf_busy = 0;
            m_perf_ops  = 0;
        end else begin
            if (m_inflight) m_perf_busy = m_perf_busy + 32'd1;
            if (!m_inflight) begin
                eop = classify(ex_inst);
                if (ex_valid && eop >= 0) begin
                    m_inflight = 1;
                    m_acked    = 0;
                    m_op       = eop;
                end
            end else if (!m_acked) begin
                if (eng_ack) begin
                    if (m_op == 0 || (m_op == 2 && eng_done)) begin
                        m_inflight = 0;
                        m_perf_ops = m_perf_ops + 16'd1;
                    end else begin
                        m_acked = 1;
                        if (m_op == 1) m_idle_at = cyc + 1 + MUL_LAT;
                    end
                end
            end else if (m_op == 1) begin
                if (cyc + 1 == m_idle_at) begin
                    m_inflight = 0;
                    m_acked    = 0;
                    m_perf_ops = m_perf_ops + 16'd1;
                end
            end else if (eng_done) begin
                m_inflight = 0;
                m_acked    = 0;
                m_perf_ops = m_perf_ops + 16'd1;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison plus simple occupancy counters for directed checks.
    bit chk_en = 0;
    int n_req = 0, n_busy = 0, n_stall = 0;
    logic exp_req, exp_stall;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_req   = m_inflight && !m_acked;
            exp_stall = id_valid && (classify(id_inst) >= 0) &&
                        (m_inflight || (ex_valid && classify(ex_inst) >= 0));
            check("busy", 32'(busy), 32'(m_inflight));
            check("eng_req", 32'(eng_req), 32'(exp_req));
            check("stall", 32'(stall), 32'(exp_stall));
            if (exp_req) check("eng_op", 32'(eng_op), 32'(m_op));
`ifdef MTYPE_PERF_EN
            check("perf_busy_cycles", perf_busy_cycles, m_perf_busy);
            check("perf_ops", 32'(perf_ops), 32'(m_perf_ops));
`endif
            if (eng_req) n_req++;
            if (busy)    n_busy++;
            if (stall)   n_stall++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        n_req = 0; n_busy = 0; n_stall = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        rst = 0; ex_valid = 0; id_valid = 0; eng_ack = 1; eng_done = 1;
        while (busy && t < 40) begin
            tick();
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        eng_ack = 0; eng_done = 0;
        tick();
    endtask

    initial begin
        // Reset held three cycles with an M2 sitting in EX.
        rst = 1; ex_valid = 1; ex_inst = mk(3'd1, OPC_CUST);
        id_valid = 0; id_inst = 32'd0; eng_ack = 0; eng_done = 0;
        tick();
        chk_en = 1;
        clr();
        tick(); tick();
        check("rst_req_cycles", 32'(n_req), 32'd0);
        check("rst_busy_cycles", 32'(n_busy), 32'd0);
        check("rst_stall_cycles", 32'(n_stall), 32'd0);
        check("rst_eng_op", 32'(eng_op), 32'd0);
        rst = 0;
        tick();
        check("accept_after_rst_req", 32'(eng_req), 32'd1);
        check("accept_after_rst_busy", 32'(busy), 32'd1);
        wait_idle();

        // M2 acked on the second request cycle; an M2 waits in ID.
        clr(); id_valid = 1; id_inst = mk(3'd1, OPC_CUST);
        for (int k = 0; k < 10; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd1, OPC_CUST);
            eng_ack = (k == 2); eng_done = 0;
            tick();
        end
        check("m2_req_cycles", 32'(n_req), 32'd2);
        check("m2_busy_cycles", 32'(n_busy), 32'd6);
        check("m2_stall_cycles", 32'(n_stall), 32'd7);
        wait_idle();

        // S completed 5 cycles after ack; stray done/ack outside the window.
        clr(); id_valid = 1; id_inst = mk(3'd2, OPC_CUST);
        for (int k = 0; k < 10; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd2, OPC_CUST);
            eng_ack = (k == 1 || k == 8); eng_done = (k == 0 || k == 6);
            tick();
        end
        check("s_req_cycles", 32'(n_req), 32'd1);
        check("s_busy_cycles", 32'(n_busy), 32'd6);
        check("s_stall_cycles", 32'(n_stall), 32'd7);
        wait_idle();

        // S with coincident ack and done.
        clr(); id_valid = 0;
        for (int k = 0; k < 4; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd2, OPC_CUST);
            eng_ack = (k == 1); eng_done = (k == 1);
            tick();
        end
        check("s_coinc_busy_cycles", 32'(n_busy), 32'd1);
        wait_idle();

        // PA with ack delayed by 3 cycles.
        clr(); id_valid = 1; id_inst = mk(3'd0, OPC_CUST);
        for (int k = 0; k < 8; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd0, OPC_CUST);
            eng_ack = (k == 4); eng_done = 0;
            tick();
        end
        check("pa_req_cycles", 32'(n_req), 32'd4);
        check("pa_busy_cycles", 32'(n_busy), 32'd4);
        check("pa_stall_cycles", 32'(n_stall), 32'd5);
        wait_idle();

        // ADD in ID while busy never stalls.
        clr(); id_valid = 1; id_inst = mk(3'd0, OPC_ALU);
        for (int k = 0; k < 8; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd1, OPC_CUST);
            eng_ack = (k == 1); eng_done = 0;
            tick();
        end
        check("add_stall_cycles", 32'(n_stall), 32'd0);
        check("add_busy_cycles", 32'(n_busy), 32'd5);
        wait_idle();

        // Reserved funct3 and an invalid EX slot are not accepted.
        clr(); id_valid = 1; id_inst = mk(3'd1, OPC_CUST);
        for (int k = 0; k < 4; k++) begin
            ex_valid = (k < 2);
            ex_inst = (k < 2) ? mk(3'd3, OPC_CUST) : mk(3'd1, OPC_CUST);
            eng_ack = 0; eng_done = 0;
            tick();
        end
        check("noaccept_busy_cycles", 32'(n_busy), 32'd0);
        check("noaccept_stall_cycles", 32'(n_stall), 32'd0);
        wait_idle();

        // Reset during MUL while the counter holds 2.
        id_valid = 0;
        for (int k = 0; k < 4; k++) begin
            ex_valid = (k == 0); ex_inst = mk(3'd1, OPC_CUST);
            eng_ack = (k == 1); eng_done = 0; rst = (k == 3);
            tick();
        end
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req", 32'(eng_req), 32'd0);
`ifdef MTYPE_PERF_EN
        check("midrst_perf_busy", perf_busy_cycles, 32'd0);
        check("midrst_perf_ops", 32'(perf_ops), 32'd0);
`endif
        rst = 0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            ex_valid = 1'($urandom_range(0, 1));
            ex_inst  = rand_inst();
            id_valid = 1'($urandom_range(0, 1));
            id_inst  = rand_inst();
            eng_ack  = ($urandom_range(0, 2) == 0);
            eng_done = ($urandom_range(0, 3) == 0);
            tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
